// File: rtl/prim_sync_reqack_pkg.sv
// Shared types for the multi-channel REQ/ACK data synchronizer.
package prim_sync_reqack_pkg;

   // Two-phase (NRZ) request/ack phase: a transaction is a phase flip.
   typedef enum logic {EVEN = 1'b0, ODD = 1'b1} nrz_phase_e;

   // Four-phase (RZ) request/ack level: HiSt while asserted, LoSt when returned to zero.
   typedef enum logic {LoSt = 1'b0, HiSt = 1'b1} rz_fsm_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for single-bit level/toggle signals crossing into clk_i.
module prim_flop_2sync #(
   parameter int               Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;

   // Two-stage capture to resolve metastability.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= ResetValue;
         q_o    <= ResetValue;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/prim_sync_reqack_data_chan.sv
// One REQ/ACK channel carrying a payload from SRC to DST.
// Handshake: SRC holds src_req_i until the one-cycle src_ack_o pulse; a
// launch happens on src_req_i & !busy & launch_ok and captures src_data_i.
// DST sees dst_req_o high with dst_data_o valid until it answers with
// dst_ack_i in the same cycle; dst_ack_i without dst_req_o is ignored.
module prim_sync_reqack_data_chan
   import prim_sync_reqack_pkg::*;
#(
   parameter int                   DataWidth = 8,
   parameter bit                   EnRzHs    = 1'b0,
   parameter logic [DataWidth-1:0] ResetData = '0
) (
   input  logic                 clk_src_i,
   input  logic                 rst_src_ni,
   input  logic                 clk_dst_i,
   input  logic                 rst_dst_ni,
   input  logic                 src_req_i,
   input  logic [DataWidth-1:0] src_data_i,
   output logic                 src_ack_o,
   output logic                 src_busy_o,
   output logic                 dst_req_o,
   output logic [DataWidth-1:0] dst_data_o,
   input  logic                 dst_ack_i
);

   logic                 busy_q, busy_d;
   logic                 req_q, req_d;
   logic                 ack_q, ack_d;
   logic                 req_s, ack_s;
   logic                 launch, launch_ok, dst_hs;
   logic [DataWidth-1:0] data_q, data_d;

   prim_flop_2sync #(.Width(1)) u_req_sync (
      .clk_i  (clk_dst_i),
      .rst_ni (rst_dst_ni),
      .d_i    (req_q),
      .q_o    (req_s)
   );

   prim_flop_2sync #(.Width(1)) u_ack_sync (
      .clk_i  (clk_src_i),
      .rst_ni (rst_src_ni),
      .d_i    (ack_q),
      .q_o    (ack_s)
   );

   assign launch = src_req_i & ~busy_q & launch_ok;
   assign dst_hs = dst_req_o & dst_ack_i;

   if (EnRzHs) begin : gen_rz
      // Four-phase: a new launch waits until the previous ack has returned to zero.
      assign launch_ok = ~ack_s;
      assign src_ack_o = busy_q & req_q & ack_s;
      assign dst_req_o = req_s & ~ack_q;

      // SRC request level: raise on launch, drop once acked.
      always_comb begin
         req_d = req_q;
         if (launch) begin
            req_d = HiSt;
         end else if (src_ack_o) begin
            req_d = LoSt;
         end
      end

      // DST ack level: raise on handshake, return to zero once the request has.
      always_comb begin
         ack_d = ack_q;
         if (dst_hs) begin
            ack_d = HiSt;
         end else if (!req_s) begin
            ack_d = LoSt;
         end
      end
   end else begin : gen_nrz
      // Two-phase: every transaction is a phase flip, so no return-to-zero wait.
      assign launch_ok = 1'b1;
      assign src_ack_o = busy_q & (ack_s == req_q);
      assign dst_req_o = req_s ^ ack_q;

      // SRC request phase flips once per launch.
      always_comb begin
         req_d = req_q;
         if (launch) begin
            req_d = (req_q == ODD) ? EVEN : ODD;
         end
      end

      // DST ack phase flips once per handshake, catching up with the request phase.
      always_comb begin
         ack_d = ack_q;
         if (dst_hs) begin
            ack_d = (ack_q == ODD) ? EVEN : ODD;
         end
      end
   end

   // SRC busy/payload next state: capture on launch, release on ack.
   always_comb begin
      busy_d = busy_q;
      data_d = data_q;
      if (launch) begin
         busy_d = 1'b1;
         data_d = src_data_i;
      end else if (src_ack_o) begin
         busy_d = 1'b0;
      end
   end

   // SRC domain registers.
   always_ff @(posedge clk_src_i or negedge rst_src_ni) begin
      if (!rst_src_ni) begin
         busy_q <= 1'b0;
         req_q  <= 1'b0;
         data_q <= ResetData;
      end else begin
         busy_q <= busy_d;
         req_q  <= req_d;
         data_q <= data_d;
      end
   end

   // DST domain register.
   always_ff @(posedge clk_dst_i or negedge rst_dst_ni) begin
      if (!rst_dst_ni) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
      end
   end

   assign src_busy_o = busy_q;
   // Quasi-static bus: data_q is frozen from launch until ack, and DST only
   // looks at it after the synchronized request rises.
   assign dst_data_o = data_q;

`ifdef INC_ASSERT
   SrcReqHeld : assert property (@(posedge clk_src_i) disable iff (!rst_src_ni)
      busy_q |-> src_req_i)
      else $error("SrcReqHeld: src_req_i dropped before src_ack_o");

   AckNeedsReq : assert property (@(posedge clk_dst_i) disable iff (!rst_dst_ni)
      dst_ack_i |-> dst_req_o)
      else $warning("AckNeedsReq: dst_ack_i seen without dst_req_o, ignored");

   DataStable : assert property (@(posedge clk_src_i) disable iff (!rst_src_ni)
      busy_q |=> $stable(data_q))
      else $error("DataStable: payload changed while in flight");
`endif

endmodule

// File: rtl/prim_sync_reqack_data_mc.sv
// NumChan independent REQ/ACK payload synchronizers; channel i uses
// bit i of the control ports and [i*DataWidth +: DataWidth] of the data ports.
module prim_sync_reqack_data_mc
   import prim_sync_reqack_pkg::*;
#(
   parameter int                   NumChan   = 1,
   parameter int                   DataWidth = 8,
   parameter bit                   EnRzHs    = 1'b0,
   parameter logic [DataWidth-1:0] ResetData = '0
) (
   input  logic                         clk_src_i,
   input  logic                         rst_src_ni,
   input  logic                         clk_dst_i,
   input  logic                         rst_dst_ni,
   input  logic [NumChan-1:0]           src_req_i,
   input  logic [NumChan*DataWidth-1:0] src_data_i,
   output logic [NumChan-1:0]           src_ack_o,
   output logic [NumChan-1:0]           src_busy_o,
   output logic [NumChan-1:0]           dst_req_o,
   output logic [NumChan*DataWidth-1:0] dst_data_o,
   input  logic [NumChan-1:0]           dst_ack_i
);

   for (genvar i = 0; i < NumChan; i++) begin : gen_chan
      prim_sync_reqack_data_chan #(
         .DataWidth (DataWidth),
         .EnRzHs    (EnRzHs),
         .ResetData (ResetData)
      ) u_chan (
         .clk_src_i  (clk_src_i),
         .rst_src_ni (rst_src_ni),
         .clk_dst_i  (clk_dst_i),
         .rst_dst_ni (rst_dst_ni),
         .src_req_i  (src_req_i[i]),
         .src_data_i (src_data_i[i*DataWidth +: DataWidth]),
         .src_ack_o  (src_ack_o[i]),
         .src_busy_o (src_busy_o[i]),
         .dst_req_o  (dst_req_o[i]),
         .dst_data_o (dst_data_o[i*DataWidth +: DataWidth]),
         .dst_ack_i  (dst_ack_i[i])
      );
   end

endmodule
